// File: rtl/reg_dump.sv
// reg_dump: debug read-out engine for the processor register file.
// On START it walks read addresses 0..NREGS-1 through one register-file
// read port, waits SETTLE_CYCLES per address for the port to settle, and
// streams each captured byte out on a valid/ready handshake with LAST on
// the final beat and a one-cycle DONE after that beat is accepted.
//
// Build option: define DUMP_CHECKSUM_EN to append one extra beat carrying
// the modulo-2^DATA_W sum of all register values. LAST then marks that
// beat instead of the last register beat.
module reg_dump #(
    parameter int NREGS         = 8,
    parameter int ADDR_W        = 3,
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic [ADDR_W-1:0] RDADDR,
    input  logic [DATA_W-1:0] RDDATA,
    output logic [DATA_W-1:0] DOUT,
    output logic              DVALID,
    input  logic              DREADY,
    output logic              LAST,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SEND
    } state_t;

    // Counter value on which the read port is considered settled.
    localparam logic [3:0]        SETTLE_END = 4'(SETTLE_CYCLES - 1);
    // Address of the last register in the sweep.
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NREGS - 1);

    state_t      state;
    logic [3:0]  settle_cnt;
    logic        accept;
    logic        final_beat;
    logic        last_reg;

    assign accept   = DVALID && DREADY;
    assign last_reg = (RDADDR == LAST_ADDR);

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
    logic              csum_beat;

    // The dump ends on the checksum beat, which follows the last register.
    assign final_beat = csum_beat;
`else
    // The dump ends on the last register beat.
    assign final_beat = last_reg;
`endif

    // Sweep FSM: address generation, settle timing, capture and handshake.
    // NOTE: every state element here uses <= so all of them update together
    // from the values seen before the edge; mixing in = would make the result
    // depend on statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            settle_cnt <= '0;
            RDADDR     <= '0;
            DOUT       <= '0;
            DVALID     <= 1'b0;
            LAST       <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            checksum   <= '0;
            csum_beat  <= 1'b0;
`endif
        end else begin
            // NOTE: DONE defaults low every cycle so a single assignment
            // below yields exactly a one-cycle pulse.
            DONE <= 1'b0;

            case (state)
                IDLE: begin
                    // RDADDR deliberately keeps its last value while idle.
                    if (START) begin
                        RDADDR     <= '0;
                        settle_cnt <= '0;
                        BUSY       <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        checksum   <= '0;
                        csum_beat  <= 1'b0;
`endif
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == SETTLE_END) begin
                        // Read port has settled: this is the only edge at
                        // which RDDATA is sampled for the current address.
                        DOUT   <= RDDATA;
                        DVALID <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        LAST   <= 1'b0;
`else
                        LAST   <= last_reg;
`endif
                        state  <= SEND;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                SEND: begin
                    // Beat is held stable until the sink accepts it.
                    if (accept) begin
                        if (final_beat) begin
                            DVALID <= 1'b0;
                            LAST   <= 1'b0;
                            BUSY   <= 1'b0;
                            DONE   <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                            csum_beat <= 1'b0;
`endif
                            state  <= IDLE;
`ifdef DUMP_CHECKSUM_EN
                        end else if (last_reg) begin
                            // Present the running sum straight away; there
                            // is no read port to settle for this beat.
                            DOUT      <= checksum + DOUT;
                            checksum  <= checksum + DOUT;
                            LAST      <= 1'b1;
                            csum_beat <= 1'b1;
`endif
                        end else begin
                            RDADDR     <= RDADDR + 1'b1;
                            settle_cnt <= '0;
                            DVALID     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                            checksum   <= checksum + DOUT;
`endif
                            state      <= SETTLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: self-checking bench for reg_dump.
// Two instances: u_dut (SETTLE_CYCLES=1, RDDATA from a register-file array)
// and u_dut3 (SETTLE_CYCLES=3, RDDATA driven with fresh random data every
// cycle so the exact sampling cycle is observable).
module tb_reg_dump;

    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
`ifdef DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam int NBEATS = NREGS + (CSUM_EN ? 1 : 0);

    logic              CLK = 1'b0;
    logic              RESET;
    logic              START;
    logic              DREADY;
    logic [DATA_W-1:0] regs [NREGS];

    logic [ADDR_W-1:0] RDADDR;
    logic [DATA_W-1:0] RDDATA;
    logic [DATA_W-1:0] DOUT;
    logic              DVALID, LAST, BUSY, DONE;

    logic              START3;
    logic              DREADY3;
    logic [DATA_W-1:0] RDDATA3;
    logic [ADDR_W-1:0] RDADDR3;
    logic [DATA_W-1:0] DOUT3;
    logic              DVALID3, LAST3, BUSY3, DONE3;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    // Register file read port: combinational read of the model array.
    assign RDDATA = regs[RDADDR];

    reg_dump #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE_CYCLES(1)) u_dut (
        .CLK(CLK), .RESET(RESET), .START(START), .RDADDR(RDADDR), .RDDATA(RDDATA),
        .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .LAST(LAST), .BUSY(BUSY), .DONE(DONE)
    );

    reg_dump #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE_CYCLES(3)) u_dut3 (
        .CLK(CLK), .RESET(RESET), .START(START3), .RDADDR(RDADDR3), .RDDATA(RDDATA3),
        .DOUT(DOUT3), .DVALID(DVALID3), .DREADY(DREADY3), .LAST(LAST3), .BUSY(BUSY3), .DONE(DONE3)
    );

    task automatic preload(input bit fixed);
        for (int i = 0; i < NREGS; i++)
            regs[i] = fixed ? DATA_W'(8'h11 * (i + 1)) : DATA_W'($urandom);
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b0; DREADY = 1'b0;
        START3 = 1'b0; DREADY3 = 1'b1; RDDATA3 = '0;
        preload(1'b0);
        repeat (3) @(negedge CLK);
        n_vec++;
        if ({RDADDR, DOUT, DVALID, LAST, BUSY, DONE} !== '0) begin
            n_err++;
            $display("FAIL reset_dut1: addr=%h dout=%h v=%b l=%b b=%b d=%b, all required 0",
                     RDADDR, DOUT, DVALID, LAST, BUSY, DONE);
        end
        n_vec++;
        if ({RDADDR3, DOUT3, DVALID3, LAST3, BUSY3, DONE3} !== '0) begin
            n_err++;
            $display("FAIL reset_dut3: addr=%h dout=%h v=%b l=%b b=%b d=%b, all required 0",
                     RDADDR3, DOUT3, DVALID3, LAST3, BUSY3, DONE3);
        end
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        n_vec++;
        if ({BUSY, DVALID, DONE} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_no_start: busy=%b valid=%b done=%b, required 000", BUSY, DVALID, DONE);
        end
    endtask

    // Cycle-exact check of a full dump with DREADY tied high.
    task automatic test_basic();
        logic [DATA_W-1:0] sum;
        int final_e;
        logic exp_v, exp_l, exp_b, exp_d;
        logic [ADDR_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_o;
        preload(1'b1);
        sum = '0;
        for (int i = 0; i < NREGS; i++) sum = sum + regs[i];
        final_e = CSUM_EN ? 2 * NREGS + 1 : 2 * NREGS;
        DREADY = 1'b1;
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        // Now just after the START edge k (e = 0).
        for (int e = 0; e <= 20; e++) begin
            exp_b = (e < final_e);
            exp_d = (e == final_e);
            exp_a = ADDR_W'((e / 2 > NREGS - 1) ? NREGS - 1 : e / 2);
            exp_v = ((e % 2 == 1) && (e < 2 * NREGS)) || (CSUM_EN && e == 2 * NREGS);
            exp_o = (e < 2 * NREGS) ? regs[(e > 0 ? e - 1 : 0) / 2] : sum;
            exp_l = CSUM_EN ? (e == 2 * NREGS) : (e == 2 * NREGS - 1);
            n_vec++;
            if ({DVALID, LAST, BUSY, DONE, RDADDR} !== {exp_v, exp_l, exp_b, exp_d, exp_a}) begin
                n_err++;
                $display("FAIL basic_ctrl e=%0d: v/l/b/d/addr=%b%b%b%b/%0d required %b%b%b%b/%0d",
                         e, DVALID, LAST, BUSY, DONE, RDADDR, exp_v, exp_l, exp_b, exp_d, exp_a);
            end
            if (exp_v) begin
                n_vec++;
                if (DOUT !== exp_o) begin
                    n_err++;
                    $display("FAIL basic_data e=%0d: DOUT=%h required %h", e, DOUT, exp_o);
                end
            end
            @(negedge CLK);
        end
    endtask

    // Run one dump with optional random back-pressure, a 5-cycle stall on
    // beat 3 and stray START pulses; collect accepted beats and compare.
    task automatic run_dump(input bit fixed, input bit rnd_ready, input bit stall3,
                            input bit poke, input string name);
        logic [DATA_W-1:0] got_d [$];
        logic              got_l [$];
        logic [DATA_W-1:0] sum, pd;
        logic              pl, prev_hold, ready, finished;
        logic [ADDR_W-1:0] pa;
        int beats, dones, stall;
        preload(fixed);
        sum = '0;
        for (int i = 0; i < NREGS; i++) sum = sum + regs[i];
        beats = 0; dones = 0; stall = 0; prev_hold = 0; finished = 0;
        pd = '0; pl = 0; pa = '0;
        DREADY = 1'b0;
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        for (int c = 0; c < 600 && !finished; c++) begin
            if (prev_hold) begin
                n_vec++;
                if (!DVALID || DOUT !== pd || LAST !== pl || RDADDR !== pa) begin
                    n_err++;
                    $display("FAIL %s hold c=%0d: v=%b dout=%h last=%b addr=%0d required 1 %h %b %0d",
                             name, c, DVALID, DOUT, LAST, RDADDR, pd, pl, pa);
                end
            end
            if (DONE) begin
                dones++;
                n_vec++;
                if (beats != NBEATS) begin
                    n_err++;
                    $display("FAIL %s early_done: beats accepted=%0d required %0d", name, beats, NBEATS);
                end
            end
            if (!BUSY) finished = 1'b1;
            if (stall3 && DVALID && beats == 3 && stall < 5) begin
                ready = 1'b0;
                stall++;
                n_vec++;
                if (DOUT !== regs[3] || RDADDR !== ADDR_W'(3)) begin
                    n_err++;
                    $display("FAIL %s stall: dout=%h addr=%0d required %h 3", name, DOUT, RDADDR, regs[3]);
                end
            end else begin
                ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            DREADY = ready;
            if (DVALID && ready) begin
                got_d.push_back(DOUT);
                got_l.push_back(LAST);
                beats++;
            end
            START = (poke && !finished) ? ($urandom_range(0, 3) == 0) : 1'b0;
            prev_hold = DVALID && !ready;
            pd = DOUT; pl = LAST; pa = RDADDR;
            @(negedge CLK);
        end
        START = 1'b0;
        DREADY = 1'b0;
        n_vec++;
        if (!finished) begin
            n_err++;
            $display("FAIL %s timeout: dump did not end, busy=%b required 0", name, BUSY);
        end
        n_vec++;
        if (dones != 1 || DONE !== 1'b0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_pulse: pulses=%0d done_now=%b busy_now=%b required 1 0 0",
                     name, dones, DONE, BUSY);
        end
        n_vec++;
        if (got_d.size() != NBEATS) begin
            n_err++;
            $display("FAIL %s beat_count: got %0d required %0d", name, got_d.size(), NBEATS);
        end
        for (int i = 0; i < NBEATS && i < got_d.size(); i++) begin
            n_vec++;
            if (got_d[i] !== ((i < NREGS) ? regs[i] : sum) || got_l[i] !== (i == NBEATS - 1)) begin
                n_err++;
                $display("FAIL %s beat%0d: dout=%h last=%b required %h %b", name, i, got_d[i], got_l[i],
                         (i < NREGS) ? regs[i] : sum, (i == NBEATS - 1));
            end
        end
    endtask

    task automatic test_stall();
        run_dump(1'b1, 1'b0, 1'b1, 1'b0, "stall");
    endtask

    task automatic test_random_ready();
        for (int n = 0; n < 4; n++) run_dump(1'b0, 1'b1, 1'b0, 1'b0, "rand_ready");
    endtask

    task automatic test_start_ignored();
        run_dump(1'b0, 1'b1, 1'b0, 1'b1, "start_busy");
    endtask

    task automatic test_reset_mid();
        bit found;
        preload(1'b1);
        DREADY = 1'b1;
        found = 1'b0;
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (DVALID && RDADDR == ADDR_W'(4)) found = 1'b1;
            else @(negedge CLK);
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL reset_mid_wait: beat 4 never presented, addr=%0d", RDADDR);
        end
        // Reset must win over a simultaneous START.
        RESET = 1'b1; START = 1'b1;
        @(negedge CLK);
        n_vec++;
        if ({RDADDR, DOUT, DVALID, LAST, BUSY, DONE} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: addr=%h dout=%h v=%b l=%b b=%b d=%b, all required 0",
                     RDADDR, DOUT, DVALID, LAST, BUSY, DONE);
        end
        RESET = 1'b0; START = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            n_vec++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_quiet c=%0d: done=%b busy=%b required 0 0", c, DONE, BUSY);
            end
        end
        run_dump(1'b1, 1'b0, 1'b0, 1'b0, "after_reset");
    endtask

    // SETTLE_CYCLES=3 instance: RDDATA3 changes every cycle; only the value
    // present during the third cycle after the address change is captured.
    task automatic test_settle3();
        logic [DATA_W-1:0] drv [0:40];
        logic [DATA_W-1:0] sum;
        logic exp_v, exp_l, exp_b, exp_d, cap;
        logic [ADDR_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_o;
        int final_t, r;
        sum = '0;
        final_t = CSUM_EN ? 4 * NREGS + 1 : 4 * NREGS;
        DREADY3 = 1'b1;
        @(negedge CLK) START3 = 1'b1;
        @(negedge CLK) START3 = 1'b0;
        for (int t = 0; t <= 37; t++) begin
            r     = (t - 3) / 4;
            cap   = (t >= 3) && ((t - 3) % 4 == 0) && (r < NREGS);
            exp_v = cap || (CSUM_EN && t == 4 * NREGS);
            exp_l = CSUM_EN ? (t == 4 * NREGS) : (cap && r == NREGS - 1);
            exp_b = (t < final_t);
            exp_d = (t == final_t);
            exp_a = ADDR_W'((t / 4 > NREGS - 1) ? NREGS - 1 : t / 4);
            exp_o = cap ? drv[t] : sum;
            n_vec++;
            if ({DVALID3, LAST3, BUSY3, DONE3, RDADDR3} !== {exp_v, exp_l, exp_b, exp_d, exp_a}) begin
                n_err++;
                $display("FAIL settle3_ctrl t=%0d: v/l/b/d/addr=%b%b%b%b/%0d required %b%b%b%b/%0d",
                         t, DVALID3, LAST3, BUSY3, DONE3, RDADDR3, exp_v, exp_l, exp_b, exp_d, exp_a);
            end
            if (exp_v) begin
                n_vec++;
                if (DOUT3 !== exp_o) begin
                    n_err++;
                    $display("FAIL settle3_data t=%0d: DOUT=%h required %h", t, DOUT3, exp_o);
                end
            end
            if (cap) sum = sum + drv[t];
            RDDATA3 = DATA_W'($urandom);
            drv[t + 1] = RDDATA3;
            @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random_ready();
        test_start_ignored();
        test_reset_mid();
        test_settle3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
